serial_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor that processes a WIDTH-bit operand pair DIGIT bits per clock through a chain of registered full-adder cells with a carry flip-flop. It is the sequential, width-generic successor to the team's single-bit half adder. Use it where area matters more than latency: arithmetic datapaths, counters-by-addition, and teaching/verification fixtures. Start/busy/done handshake; results held until the next completion.

---
 rtl/serial_adder_pkg.sv | 21 ++
 rtl/serial_adder_full_adder.sv | 20 ++
 rtl/serial_adder.sv | 157 +++++++++++++++
 tb/tb_serial_adder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder: FSM encoding and parameter helpers
// used for elaboration-time checks and counter sizing.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Legal geometry: at least two result bits and a digit that tiles the word.
  function automatic bit digit_ok(input int width, input int digit);
    return (width >= 2) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

  // Counter must hold 0 .. WIDTH/DIGIT without wrapping.
  function automatic int cnt_width(input int width, input int digit);
    return $clog2(width / digit) + 1;
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder built from two half-adder stages whose carries are ORed.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic ha0_s;
  logic ha0_c;
  logic ha1_c;

  assign ha0_s = a ^ b;
  assign ha0_c = a & b;
  assign s     = ha0_s ^ cin;
  assign ha1_c = ha0_s & cin;
  assign cout  = ha0_c | ha1_c;

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: consumes DIGIT bits of the operand pair per
// clock through a chain of full adders, with a start/busy/done handshake.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (!digit_ok(WIDTH, DIGIT)) begin : g_bad_geometry
    $error("serial_adder: WIDTH must be >= 2 and DIGIT must divide WIDTH");
  end

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT:0]   chain_c;
  logic [DIGIT-1:0] digit_s;
  logic [WIDTH-1:0] digit_ext;
  logic [WIDTH-1:0] res_next;
  logic             accept;

  assign chain_c[0] = carry_q;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    full_adder u_fa (
      .a    (a_q[i]),
      .b    (b_q[i]),
      .cin  (chain_c[i]),
      .s    (digit_s[i]),
      .cout (chain_c[i+1])
    );
  end

  // Each new digit enters at the top; after N digits the first lands at bit 0.
  always_comb begin
    digit_ext              = '0;
    digit_ext[DIGIT-1:0]   = digit_s;
    res_next               = (res_q >> DIGIT) | (digit_ext << (WIDTH - DIGIT));
  end

  // The DONE exit edge doubles as the earliest accept point, giving one
  // operation every N+1 cycles when start is held high.
  assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  always_comb begin
    // NOTE: every _d takes its held value first, so no path through this block infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: ;
      ST_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        res_d   = res_next;
        carry_d = chain_c[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = res_next;
          cout_d  = chain_c[DIGIT];
          ovf_d   = chain_c[DIGIT] ^ chain_c[DIGIT-1];
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Subtraction is a + ~b + 1: invert B on capture and seed the carry.
    if (accept) begin
      a_d     = a;
      b_d     = b ^ {WIDTH{sub}};
      carry_d = sub;
      cnt_d   = '0;
      res_d   = '0;
      busy_d  = 1'b1;
      state_d = ST_RUN;
    end
  end

  // NOTE: state is updated only with non-blocking assignments, and every register,
  // datapath included, is cleared by reset so an abort leaves nothing stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder in three geometries: 8x1, 8x4 and 4x2.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // WIDTH=8, DIGIT=1
  logic       s8_start, s8_sub, s8_busy, s8_done, s8_cout, s8_ovf;
  logic [7:0] s8_a, s8_b, s8_sum;
  // WIDTH=8, DIGIT=4
  logic       q_start, q_sub, q_busy, q_done, q_cout, q_ovf;
  logic [7:0] q_a, q_b, q_sum;
  // WIDTH=4, DIGIT=2
  logic       e_start, e_sub, e_busy, e_done, e_cout, e_ovf;
  logic [3:0] e_a, e_b, e_sum;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut8 (
    .clk(clk), .rst(rst), .start(s8_start), .sub(s8_sub), .a(s8_a), .b(s8_b),
    .busy(s8_busy), .done(s8_done), .sum(s8_sum), .cout(s8_cout), .ovf(s8_ovf)
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_dut84 (
    .clk(clk), .rst(rst), .start(q_start), .sub(q_sub), .a(q_a), .b(q_b),
    .busy(q_busy), .done(q_done), .sum(q_sum), .cout(q_cout), .ovf(q_ovf)
  );

  serial_adder #(.WIDTH(4), .DIGIT(2)) u_dut42 (
    .clk(clk), .rst(rst), .start(e_start), .sub(e_sub), .a(e_a), .b(e_b),
    .busy(e_busy), .done(e_done), .sum(e_sum), .cout(e_cout), .ovf(e_ovf)
  );

  typedef struct {
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference from signed/unsigned integer arithmetic; returns {cout, ovf, sum}.
  function automatic logic [5:0] model4(input logic sub, input logic [3:0] a, input logic [3:0] b);
    int         sa, sb, r;
    logic [3:0] s;
    logic       c, v;
    sa = a[3] ? int'(a) - 16 : int'(a);
    sb = b[3] ? int'(b) - 16 : int'(b);
    if (sub) begin
      r = sa - sb;
      s = a - b;
      c = (a >= b);
    end else begin
      r = sa + sb;
      s = a + b;
      c = (int'(a) + int'(b)) > 15;
    end
    v = (r > 7) || (r < -8);
    return {c, v, s};
  endfunction

  // Issue one operation on the 8x1 instance; called at a negedge.
  // Operands are scrambled after capture; an optional start pulse with other
  // operands is driven at RUN index pulse_at.
  task automatic op8(input logic sub, input logic [7:0] a, input logic [7:0] b,
                     input int pulse_at, output int lat, output int busy_n);
    s8_start = 1'b1;
    s8_sub   = sub;
    s8_a     = a;
    s8_b     = b;
    @(posedge clk);
    lat    = 40;
    busy_n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      s8_start = (k == pulse_at);
      if (k == 0) begin
        s8_a   = ~a;
        s8_b   = a ^ b;
        s8_sub = ~sub;
      end
      if (k == pulse_at) begin
        s8_a   = 8'h11;
        s8_b   = 8'h22;
        s8_sub = 1'b1;
      end
      if (s8_done) begin
        lat = k;
        break;
      end
      if (s8_busy) busy_n++;
    end
    s8_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int         lat, busy_n, n_done, k;
  logic       got;
  logic [8:0] nxt;
  logic [8:0] cur;

  initial begin
    vecs[0] = '{sub: 1'b0, a: 8'h3C, b: 8'h5A, sum: 8'h96, cout: 1'b0, ovf: 1'b1};
    vecs[1] = '{sub: 1'b0, a: 8'hFF, b: 8'h01, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
    vecs[2] = '{sub: 1'b1, a: 8'h05, b: 8'h07, sum: 8'hFE, cout: 1'b0, ovf: 1'b0};
    vecs[3] = '{sub: 1'b1, a: 8'h80, b: 8'h01, sum: 8'h7F, cout: 1'b1, ovf: 1'b1};
    vecs[4] = '{sub: 1'b0, a: 8'h7F, b: 8'h7F, sum: 8'hFE, cout: 1'b0, ovf: 1'b1};
    vecs[5] = '{sub: 1'b1, a: 8'h10, b: 8'h10, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
    vecs[6] = '{sub: 1'b1, a: 8'h00, b: 8'h80, sum: 8'h80, cout: 1'b0, ovf: 1'b1};
    vecs[7] = '{sub: 1'b0, a: 8'h00, b: 8'h00, sum: 8'h00, cout: 1'b0, ovf: 1'b0};

    rst = 1'b1;
    {s8_start, s8_sub, s8_a, s8_b} = '0;
    {q_start, q_sub, q_a, q_b}     = '0;
    {e_start, e_sub, e_a, e_b}     = '0;
    repeat (2) @(negedge clk);
    check("reset_8x1", {s8_busy, s8_done, s8_cout, s8_ovf, s8_sum}, '0);
    check("reset_8x4", {q_busy, q_done, q_cout, q_ovf, q_sum}, '0);
    check("reset_4x2", {e_busy, e_done, e_cout, e_ovf, e_sum}, '0);
    rst = 1'b0;
    @(negedge clk);

    // Table of 8x1 operations with latency and done-width checks.
    for (int i = 0; i < 8; i++) begin
      op8(vecs[i].sub, vecs[i].a, vecs[i].b, -1, lat, busy_n);
      check($sformatf("vec%0d_latency", i), lat, 8);
      check($sformatf("vec%0d_busy_cycles", i), busy_n, 8);
      check($sformatf("vec%0d_result", i), {s8_cout, s8_ovf, s8_sum},
            {vecs[i].cout, vecs[i].ovf, vecs[i].sum});
      @(negedge clk);
      check($sformatf("vec%0d_done_width", i), s8_done, 1'b0);
    end

    // start pulsed during RUN must be ignored; result then holds while idle.
    op8(1'b0, 8'h3C, 8'h5A, 3, lat, busy_n);
    check("ignore_latency", lat, 8);
    check("ignore_result", {s8_cout, s8_ovf, s8_sum}, {1'b0, 1'b1, 8'h96});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("hold_%0d", i), {s8_busy, s8_done, s8_cout, s8_ovf, s8_sum},
            {1'b0, 1'b0, 1'b0, 1'b1, 8'h96});
    end

    // 8x4: start held high, accepted every N+1 = 3 cycles.
    q_start = 1'b1;
    q_sub   = 1'b0;
    q_a     = 8'h7F;
    q_b     = 8'h01;
    @(posedge clk);
    n_done = 0;
    for (int kk = 0; kk < 12; kk++) begin
      @(negedge clk);
      if (kk == 3) check("d4_busy_reaccept", q_busy, 1'b1);
      if (q_done) begin
        check($sformatf("d4_done_at_%0d", n_done), kk, 2 + 3 * n_done);
        check($sformatf("d4_result_%0d", n_done), {q_cout, q_ovf, q_sum}, {1'b0, 1'b1, 8'h80});
        n_done++;
      end
      if (kk == 11) q_start = 1'b0;
    end
    check("d4_done_count", n_done, 4);
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of a RUN on the 8x1 instance.
    s8_start = 1'b1;
    s8_sub   = 1'b0;
    s8_a     = 8'h12;
    s8_b     = 8'h34;
    @(posedge clk);
    for (int kk = 0; kk < 5; kk++) begin
      @(negedge clk);
      if (kk == 0) s8_start = 1'b0;
    end
    check("pre_reset_busy", s8_busy, 1'b1);
    rst = 1'b1;
    #1;
    check("abort_8x1", {s8_busy, s8_done, s8_cout, s8_ovf, s8_sum}, '0);
    check("abort_8x4", {q_busy, q_done, q_cout, q_ovf, q_sum}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("no_done_after_abort_%0d", i), {s8_busy, s8_done}, 2'b00);
    end
    op8(1'b0, 8'h12, 8'h34, -1, lat, busy_n);
    check("post_reset_latency", lat, 8);
    check("post_reset_result", {s8_cout, s8_ovf, s8_sum}, {1'b0, 1'b0, 8'h46});
    @(negedge clk);

    // 4x2: exhaustive a, b, sub with start held high (back-to-back issue).
    e_start = 1'b1;
    {e_sub, e_a, e_b} = 9'd0;
    for (int i = 0; i < 512; i++) begin
      cur = 9'(i);
      @(posedge clk);
      k   = 0;
      got = 1'b0;
      while (k < 20 && !got) begin
        @(negedge clk);
        if (k == 0) begin
          e_a   = ~e_a;
          e_b   = e_b + 4'd5;
          e_sub = ~e_sub;
        end
        if (e_done) got = 1'b1;
        else        k++;
      end
      check($sformatf("ex_latency_%0d", i), k, 2);
      check($sformatf("ex_result_%0d", i), {e_cout, e_ovf, e_sum},
            model4(cur[8], cur[7:4], cur[3:0]));
      if (i < 511) begin
        nxt = 9'(i + 1);
        {e_sub, e_a, e_b} = nxt;
      end else begin
        e_start = 1'b0;
      end
    end
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
